// File: rtl/alarm_controller.sv
// Alarm sequencer: stores the alarm time, detects the minute match and runs the ring/snooze/stop FSM.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and snooze counters.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 540,
  parameter int MAX_SNOOZES    = 3,
  parameter int ALARM_HOUR_RST = 6,
  parameter int ALARM_MIN_RST  = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic [6:0] time_hour,
  input  logic [6:0] time_minute,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_minute,
  input  logic       arm_toggle,
  input  logic       snooze,
  input  logic       stop,
  output logic [6:0] alarm_hour,
  output logic [6:0] alarm_minute,
  output logic       armed,
  output logic       buzzer,
  output logic       snoozing,
  output logic       setting,
  output logic [1:0] snooze_count
);

  typedef enum logic [2:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_SET,
    ST_RINGING
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZE
`endif
  } state_t;

  localparam logic [9:0] RING_LAST = 10'(RING_SECONDS - 1);
  localparam logic [6:0] HOUR_RST  = 7'(ALARM_HOUR_RST);
  localparam logic [6:0] MIN_RST   = 7'(ALARM_MIN_RST);

  state_t     state, state_n;
  logic       armed_q, armed_n;
  logic [6:0] hour_q, hour_n;
  logic [6:0] minute_q, minute_n;
  logic [9:0] ring_cnt, ring_n;
  logic       match, match_q, trigger;
  logic       buzzer_q, setting_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
  localparam logic [1:0] MAX_CNT     = 2'(MAX_SNOOZES);

  logic [9:0] snz_cnt, snz_n;
  logic [1:0] count_q, count_n;
  logic       snoozing_q;
`endif

  // Edge-detect the match so the alarm fires once per matching minute.
  assign match   = (time_hour == hour_q) && (time_minute == minute_q);
  assign trigger = match & ~match_q;

  always_comb begin
    state_n  = state;
    armed_n  = armed_q;
    hour_n   = hour_q;
    minute_n = minute_q;
    ring_n   = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_n    = snz_cnt;
    count_n  = count_q;
`endif
    case (state)
      ST_DISARMED: begin
        if (arm_toggle) begin
          state_n = ST_ARMED;
          armed_n = 1'b1;
        end else if (set_mode) begin
          state_n = ST_SET;
        end
      end
      ST_ARMED: begin
        if (arm_toggle) begin
          state_n = ST_DISARMED;
          armed_n = 1'b0;
        end else if (set_mode) begin
          state_n = ST_SET;
        end else if (trigger) begin
          state_n = ST_RINGING;
          ring_n  = '0;
`ifdef ALARM_SNOOZE_EN
          count_n = '0;
`endif
        end
      end
      ST_SET: begin
        if (inc_hour)
          hour_n = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
        if (inc_minute)
          minute_n = (minute_q == 7'd59) ? 7'd0 : minute_q + 7'd1;
        if (arm_toggle)
          armed_n = ~armed_q;
        else if (set_mode)
          state_n = armed_q ? ST_ARMED : ST_DISARMED;
      end
      ST_RINGING: begin
        if (arm_toggle) begin
          state_n = ST_DISARMED;
          armed_n = 1'b0;
        end else if (stop) begin
          state_n = ST_ARMED;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze && (count_q < MAX_CNT)) begin
          state_n = ST_SNOOZE;
          snz_n   = '0;
          count_n = count_q + 2'd1;
        end
`endif
        else if (tick_1s) begin
          if (ring_cnt == RING_LAST) begin
            state_n = ST_ARMED;
            ring_n  = '0;
          end else begin
            ring_n = ring_cnt + 10'd1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (arm_toggle) begin
          state_n = ST_DISARMED;
          armed_n = 1'b0;
        end else if (stop) begin
          state_n = ST_ARMED;
        end else if (tick_1s) begin
          if (snz_cnt == SNOOZE_LAST) begin
            state_n = ST_RINGING;
            snz_n   = '0;
            ring_n  = '0;
          end else begin
            snz_n = snz_cnt + 10'd1;
          end
        end
      end
`endif
      default: state_n = ST_DISARMED;
    endcase
`ifdef ALARM_SNOOZE_EN
    if (state_n inside {ST_ARMED, ST_DISARMED})
      count_n = '0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_DISARMED;
      armed_q   <= 1'b0;
      hour_q    <= HOUR_RST;
      minute_q  <= MIN_RST;
      ring_cnt  <= '0;
      match_q   <= 1'b0;
      buzzer_q  <= 1'b0;
      setting_q <= 1'b0;
    end else begin
      state     <= state_n;
      armed_q   <= armed_n;
      hour_q    <= hour_n;
      minute_q  <= minute_n;
      ring_cnt  <= ring_n;
      match_q   <= match;
      buzzer_q  <= (state_n == ST_RINGING);
      setting_q <= (state_n == ST_SET);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snz_cnt    <= '0;
      count_q    <= '0;
      snoozing_q <= 1'b0;
    end else begin
      snz_cnt    <= snz_n;
      count_q    <= count_n;
      snoozing_q <= (state_n == ST_SNOOZE);
    end
  end

  assign snoozing     = snoozing_q;
  assign snooze_count = count_q;
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze, SNOOZE_SECONDS[0], MAX_SNOOZES[0]};

  assign snoozing     = 1'b0;
  assign snooze_count = 2'd0;
`endif

  assign alarm_hour   = hour_q;
  assign alarm_minute = minute_q;
  assign armed        = armed_q;
  assign buzzer       = buzzer_q;
  assign setting      = setting_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: a countdown-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alarm_controller;

  localparam int RING_S = 4;
  localparam int SNZ_S  = 3;
  localparam int MAX_S  = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif

  localparam logic [6:0] P_TICK = 7'b1000000;
  localparam logic [6:0] P_SET  = 7'b0100000;
  localparam logic [6:0] P_IH   = 7'b0010000;
  localparam logic [6:0] P_IM   = 7'b0001000;
  localparam logic [6:0] P_ARM  = 7'b0000100;
  localparam logic [6:0] P_SNZ  = 7'b0000010;
  localparam logic [6:0] P_STOP = 7'b0000001;

  localparam int M_OFF = 0, M_ON = 1, M_SET = 2, M_RING = 3, M_SNZ = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1s, set_mode, inc_hour, inc_minute, arm_toggle, snooze, stop;
  logic [6:0] time_hour, time_minute;
  logic [6:0] alarm_hour, alarm_minute;
  logic       armed, buzzer, snoozing, setting;
  logic [1:0] snooze_count;

  int errors = 0;
  int checks = 0;

  alarm_controller #(
    .RING_SECONDS(RING_S),
    .SNOOZE_SECONDS(SNZ_S),
    .MAX_SNOOZES(MAX_S),
    .ALARM_HOUR_RST(6),
    .ALARM_MIN_RST(30)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tick_1s(tick_1s),
    .time_hour(time_hour),
    .time_minute(time_minute),
    .set_mode(set_mode),
    .inc_hour(inc_hour),
    .inc_minute(inc_minute),
    .arm_toggle(arm_toggle),
    .snooze(snooze),
    .stop(stop),
    .alarm_hour(alarm_hour),
    .alarm_minute(alarm_minute),
    .armed(armed),
    .buzzer(buzzer),
    .snoozing(snoozing),
    .setting(setting),
    .snooze_count(snooze_count)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: seconds remaining count down; modes are plain integers.
  int m_mode, m_armed, m_ah, m_am, m_cnt, m_ring_left, m_snz_left, m_prev;
  int hit, fresh;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = M_OFF; m_armed = 0; m_ah = 6; m_am = 30; m_cnt = 0;
      m_ring_left = 0; m_snz_left = 0; m_prev = 0;
    end else begin
      hit   = (int'(time_hour) == m_ah && int'(time_minute) == m_am) ? 1 : 0;
      fresh = (hit == 1 && m_prev == 0) ? 1 : 0;
      m_prev = hit;
      case (m_mode)
        M_OFF:
          if (arm_toggle) begin m_mode = M_ON; m_armed = 1; end
          else if (set_mode) m_mode = M_SET;
        M_ON:
          if (arm_toggle) begin m_mode = M_OFF; m_armed = 0; end
          else if (set_mode) m_mode = M_SET;
          else if (fresh == 1) begin m_mode = M_RING; m_ring_left = RING_S; m_cnt = 0; end
        M_SET: begin
          if (inc_hour) m_ah = (m_ah + 1) % 24;
          if (inc_minute) m_am = (m_am + 1) % 60;
          if (arm_toggle) m_armed = 1 - m_armed;
          else if (set_mode) m_mode = (m_armed == 1) ? M_ON : M_OFF;
        end
        M_RING:
          if (arm_toggle) begin m_mode = M_OFF; m_armed = 0; m_cnt = 0; end
          else if (stop) begin m_mode = M_ON; m_cnt = 0; end
          else if (SNOOZE_EN && snooze && m_cnt < MAX_S) begin
            m_mode = M_SNZ; m_snz_left = SNZ_S; m_cnt = m_cnt + 1;
          end else if (tick_1s) begin
            m_ring_left = m_ring_left - 1;
            if (m_ring_left == 0) begin m_mode = M_ON; m_cnt = 0; end
          end
        default:
          if (arm_toggle) begin m_mode = M_OFF; m_armed = 0; m_cnt = 0; end
          else if (stop) begin m_mode = M_ON; m_cnt = 0; end
          else if (tick_1s) begin
            m_snz_left = m_snz_left - 1;
            if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RING_S; end
          end
      endcase
    end
  end

  always @(posedge clock) begin
    #1;
    check_output("cyc_alarm_hour", alarm_hour, m_ah);
    check_output("cyc_alarm_minute", alarm_minute, m_am);
    check_output("cyc_armed", armed, m_armed);
    check_output("cyc_buzzer", buzzer, (m_mode == M_RING) ? 1 : 0);
    check_output("cyc_snoozing", snoozing, (m_mode == M_SNZ) ? 1 : 0);
    check_output("cyc_setting", setting, (m_mode == M_SET) ? 1 : 0);
    check_output("cyc_snooze_count", snooze_count, m_cnt);
  end

  // Drives one cycle's worth of pulses at the falling edge; they are sampled at the next rising edge.
  task automatic apply_stimulus(input logic [6:0] p);
    @(negedge clock);
    {tick_1s, set_mode, inc_hour, inc_minute, arm_toggle, snooze, stop} = p;
  endtask

  task automatic set_time(input int h, input int m);
    @(negedge clock);
    {tick_1s, set_mode, inc_hour, inc_minute, arm_toggle, snooze, stop} = '0;
    time_hour   = 7'(h);
    time_minute = 7'(m);
  endtask

  task automatic ring_again(input int h, input int m);
    set_time(h, m + 1);
    set_time(h, m);
    apply_stimulus(0);
    check_output("ring_again_buzzer", buzzer, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    {tick_1s, set_mode, inc_hour, inc_minute, arm_toggle, snooze, stop} = '0;
    time_hour = 7'd12;
    time_minute = 7'd0;
    repeat (3) @(negedge clock);
    check_output("rst_alarm_hour", alarm_hour, 6);
    check_output("rst_alarm_minute", alarm_minute, 30);
    check_output("rst_armed", armed, 0);
    check_output("rst_buzzer", buzzer, 0);
    check_output("rst_snooze_count", snooze_count, 0);
    reset = 1'b1;

    // Set the alarm with wrap on both fields and no hour carry.
    apply_stimulus(P_SET);
    apply_stimulus(0);
    check_output("set_entered", setting, 1);
    for (int i = 0; i < 18; i++) apply_stimulus(P_IH);
    for (int i = 0; i < 30; i++) apply_stimulus(P_IM);
    apply_stimulus(P_SET);
    apply_stimulus(0);
    check_output("set_hour_wrap", alarm_hour, 0);
    check_output("set_minute_wrap", alarm_minute, 0);
    check_output("set_left", setting, 0);
    check_output("set_disarmed", armed, 0);

    // Arm and trigger across the midnight boundary.
    set_time(23, 59);
    apply_stimulus(P_ARM);
    apply_stimulus(0);
    check_output("arm_flag", armed, 1);
    set_time(0, 0);
    check_output("trig_same_cycle", buzzer, 0);
    apply_stimulus(0);
    check_output("trig_buzzer", buzzer, 1);
    apply_stimulus(P_TICK);
    apply_stimulus(P_TICK);
    apply_stimulus(P_TICK);
    apply_stimulus(0);
    check_output("ring_3_ticks", buzzer, 1);
    apply_stimulus(P_TICK);
    apply_stimulus(0);
    check_output("auto_stop_buzzer", buzzer, 0);
    check_output("auto_stop_armed", armed, 1);
    repeat (5) apply_stimulus(0);
    check_output("no_retrigger", buzzer, 0);

    // A match that appears while in SET is discarded.
    set_time(0, 1);
    apply_stimulus(P_SET);
    set_time(0, 0);
    apply_stimulus(P_SET);
    apply_stimulus(0);
    check_output("set_trig_buzzer", buzzer, 0);
    check_output("set_trig_armed", armed, 1);

    // Asynchronous reset in the middle of a ring.
    ring_again(0, 0);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_buzzer", buzzer, 0);
    check_output("async_rst_armed", armed, 0);
    check_output("async_rst_hour", alarm_hour, 6);
    @(negedge clock);
    reset = 1'b1;

    set_time(6, 29);
    apply_stimulus(P_ARM);
    set_time(6, 30);
    apply_stimulus(0);
    check_output("ring_0630", buzzer, 1);
    if (SNOOZE_EN) begin
      apply_stimulus(P_SNZ);
      apply_stimulus(0);
      check_output("snz1_snoozing", snoozing, 1);
      check_output("snz1_buzzer", buzzer, 0);
      check_output("snz1_count", snooze_count, 1);
      repeat (3) apply_stimulus(P_TICK);
      apply_stimulus(0);
      check_output("snz1_reringing", buzzer, 1);
      apply_stimulus(P_SNZ);
      apply_stimulus(0);
      check_output("snz2_count", snooze_count, 2);
      repeat (3) apply_stimulus(P_TICK);
      apply_stimulus(0);
      check_output("snz2_reringing", buzzer, 1);
      apply_stimulus(P_SNZ);
      apply_stimulus(0);
      check_output("snz3_ignored_buzzer", buzzer, 1);
      check_output("snz3_ignored_snoozing", snoozing, 0);
      check_output("snz3_count", snooze_count, 2);
      apply_stimulus(P_STOP);
      apply_stimulus(0);
      check_output("stop_buzzer", buzzer, 0);
      check_output("stop_count", snooze_count, 0);
      check_output("stop_armed", armed, 1);
    end else begin
      apply_stimulus(P_SNZ);
      apply_stimulus(0);
      check_output("nosnz_buzzer", buzzer, 1);
      check_output("nosnz_snoozing", snoozing, 0);
      repeat (3) apply_stimulus(P_TICK);
      apply_stimulus(0);
      check_output("nosnz_3_ticks", buzzer, 1);
      apply_stimulus(P_TICK);
      apply_stimulus(0);
      check_output("nosnz_timeout", buzzer, 0);
      check_output("nosnz_armed", armed, 1);
      check_output("nosnz_count", snooze_count, 0);
    end

    // Same-cycle priorities.
    ring_again(6, 30);
    apply_stimulus(P_STOP | P_SNZ);
    apply_stimulus(0);
    check_output("stop_snz_buzzer", buzzer, 0);
    check_output("stop_snz_snoozing", snoozing, 0);
    check_output("stop_snz_armed", armed, 1);
    ring_again(6, 30);
    apply_stimulus(P_ARM | P_STOP);
    apply_stimulus(0);
    check_output("arm_stop_buzzer", buzzer, 0);
    check_output("arm_stop_armed", armed, 0);

    repeat (3) apply_stimulus(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
